// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits; uart_txd is a flop.
// Latency: line falls one cycle after acceptance. No buffering; ready only in IDLE, or valid held at frame end chains the next frame.
module uart_tx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    uart_txd,
  input  logic                    uart_tx_valid,
  output logic                    uart_tx_ready,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_busy
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int IW = $clog2(PAYLOAD_BITS);

  generate
    if (CYCLES_PER_BIT < 2 || PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY < 0 || PARITY > 2) begin : g_bad_params
      $error("uart_tx: unsupported parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CW-1:0]           cyc_cnt;
  logic [IW-1:0]           bit_idx;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic [PAYLOAD_BITS-1:0] shreg_nxt;
  logic                    par_bit;
  logic                    txd_nxt;
  logic                    bit_done;
  logic                    data_last;
  logic                    stop_last;
  logic                    accept;

  assign bit_done  = (cyc_cnt == CW'(CYCLES_PER_BIT - 1));
  assign data_last = (bit_idx == IW'(PAYLOAD_BITS - 1));
  assign stop_last = (bit_idx == IW'(STOP_BITS - 1));
  // Valid still high on the final stop cycle starts the next frame with no idle gap.
  assign accept    = uart_tx_valid &&
                     ((state == S_IDLE) || (state == S_STOP && bit_done && stop_last));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      uart_txd <= 1'b1;
    end else begin
      state    <= state_nxt;
      uart_txd <= txd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_START;
      S_START:  if (bit_done) state_nxt = S_DATA;
      S_DATA:   if (bit_done && data_last) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) state_nxt = S_STOP;
      S_STOP:   if (bit_done && stop_last) state_nxt = accept ? S_START : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    shreg_nxt = shreg;
    if (accept) begin
      shreg_nxt = uart_tx_data;
    end else if (state == S_DATA && bit_done) begin
      shreg_nxt = shreg >> 1;
    end
    case (state_nxt)
      S_START:  txd_nxt = 1'b0;
      S_DATA:   txd_nxt = shreg_nxt[0];
      S_PARITY: txd_nxt = par_bit;
      default:  txd_nxt = 1'b1;
    endcase
    uart_tx_ready = (state == S_IDLE);
    uart_tx_busy  = (state != S_IDLE);
  end

  // The bit index counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      cyc_cnt <= (state == S_IDLE || bit_done) ? '0 : cyc_cnt + 1'b1;
      if (state_nxt != state) begin
        bit_idx <= '0;
      end else if (bit_done && (state == S_DATA || state == S_STOP)) begin
        bit_idx <= bit_idx + 1'b1;
      end
      shreg <= shreg_nxt;
      if (accept) begin
        par_bit <= (PARITY == 1) ? ~^uart_tx_data : ^uart_tx_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E2, 7O1) at 10 clocks per bit,
// frames predicted from the framing rules and compared cycle by cycle on the line.
module tb_uart_tx;

  localparam int CPB  = 10;
  localparam int NDUT = 3;
  localparam int PB  [NDUT] = '{8, 8, 7};
  localparam int PAR [NDUT] = '{0, 2, 1};
  localparam int SB  [NDUT] = '{1, 2, 1};

  typedef struct {
    logic [15:0] bits;
    int          nbits;
  } frame_t;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic [NDUT-1:0] txd;
  logic [NDUT-1:0] rdy;
  logic [NDUT-1:0] busy;
  logic [NDUT-1:0] vld;
  logic [7:0]      dat [NDUT];

  int     tests = 0;
  int     fails = 0;
  int     edge_cnt = 0;
  int     free_edge [NDUT];
  int     acc_cnt   [NDUT];
  int     acc_edge  [NDUT];
  bit     chk_en = 1'b0;
  frame_t exp_q [NDUT][$];

  always #5 clk = ~clk;

  uart_tx #(.BIT_RATE(100000), .CLK_HZ(1000000), .PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY(0)) dut_8n1 (
    .clk(clk), .reset(reset), .uart_txd(txd[0]), .uart_tx_valid(vld[0]),
    .uart_tx_ready(rdy[0]), .uart_tx_data(dat[0]), .uart_tx_busy(busy[0]));

  uart_tx #(.BIT_RATE(100000), .CLK_HZ(1000000), .PAYLOAD_BITS(8), .STOP_BITS(2), .PARITY(2)) dut_8e2 (
    .clk(clk), .reset(reset), .uart_txd(txd[1]), .uart_tx_valid(vld[1]),
    .uart_tx_ready(rdy[1]), .uart_tx_data(dat[1]), .uart_tx_busy(busy[1]));

  uart_tx #(.BIT_RATE(100000), .CLK_HZ(1000000), .PAYLOAD_BITS(7), .STOP_BITS(1), .PARITY(1)) dut_7o1 (
    .clk(clk), .reset(reset), .uart_txd(txd[2]), .uart_tx_valid(vld[2]),
    .uart_tx_ready(rdy[2]), .uart_tx_data(dat[2][6:0]), .uart_tx_busy(busy[2]));

  function automatic frame_t mk_frame(int g, logic [7:0] d);
    frame_t     f;
    logic [7:0] m;
    int         n;
    m = d & 8'((1 << PB[g]) - 1);
    f.bits = '0;
    f.bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < PB[g]; i++) begin
      f.bits[n] = m[i];
      n++;
    end
    if (PAR[g] == 2) begin
      f.bits[n] = ^m;
      n++;
    end else if (PAR[g] == 1) begin
      f.bits[n] = ~^m;
      n++;
    end
    for (int s = 0; s < SB[g]; s++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits = n;
    return f;
  endfunction

  function automatic void check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Reference model: a byte is taken when valid is high and the previous frame has finished.
  always @(posedge clk) begin : p_model
    frame_t f;
    edge_cnt++;
    for (int g = 0; g < NDUT; g++) begin
      if (reset) begin
        free_edge[g] = edge_cnt;
        exp_q[g].delete();
      end else if (vld[g] && edge_cnt >= free_edge[g]) begin
        f = mk_frame(g, dat[g]);
        exp_q[g].push_back(f);
        free_edge[g] = edge_cnt + f.nbits * CPB;
        acc_cnt[g]++;
        acc_edge[g] = edge_cnt;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < NDUT; g++) begin
        tests++;
        if (rdy[g] !== (edge_cnt >= free_edge[g]) || busy[g] !== ~rdy[g]) begin
          fails++;
          $display("FAIL ready_dut%0d edge %0d: ready=%b busy=%b, expected ready=%b busy=%b",
                   g, edge_cnt, rdy[g], busy[g], (edge_cnt >= free_edge[g]), (edge_cnt < free_edge[g]));
        end
      end
    end
  end

  for (genvar g = 0; g < NDUT; g++) begin : g_mon
    initial begin
      frame_t f;
      int     errs;
      int     j;
      int     first_j;
      logic   first_got;
      forever begin
        @(negedge clk);
        if (chk_en && !reset && txd[g] === 1'b0) begin
          if (exp_q[g].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL frame_dut%0d: line went low with no byte accepted (got 0, expected 1)", g);
            while (txd[g] !== 1'b1) @(negedge clk);
          end else begin
            f = exp_q[g].pop_front();
            errs = 0;
            first_j = -1;
            first_got = 1'b0;
            for (j = 0; j < f.nbits * CPB; j++) begin
              if (j > 0) @(negedge clk);
              if (reset) break;
              if (txd[g] !== f.bits[j / CPB]) begin
                if (errs == 0) begin
                  first_j = j;
                  first_got = txd[g];
                end
                errs++;
              end
            end
            tests++;
            if (errs != 0) begin
              fails++;
              $display("FAIL frame_dut%0d: cycle %0d of frame got %b, expected %b (%0d bad cycles, frame bits %b)",
                       g, first_j, first_got, f.bits[first_j / CPB], errs, f.bits);
            end
          end
        end
      end
    end
  end

  // Call right after a posedge (+1); returns at posedge+1 of the acceptance edge.
  task automatic send(int g, logic [7:0] d);
    int c0;
    int n;
    c0 = acc_cnt[g];
    vld[g] = 1'b1;
    dat[g] = d;
    n = 0;
    while (acc_cnt[g] == c0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    vld[g] = 1'b0;
    dat[g] = 8'($urandom);
  endtask

  task automatic measure_busy(int g, int req, string name);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy[g] !== 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check(name, n, req);
  endtask

  task automatic wait_idle();
    int n;
    bit idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      idle = 1'b1;
      for (int g = 0; g < NDUT; g++) begin
        if (edge_cnt < free_edge[g] || exp_q[g].size() != 0) idle = 1'b0;
      end
    end
    check("drain_timeout", idle ? 0 : 1, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rand_burst(int g);
    int gap;
    for (int i = 0; i < 12; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      send(g, 8'($urandom));
    end
  endtask

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int bad;
    int k1;
    int c0;
    int n;
    vld = '0;
    for (int g = 0; g < NDUT; g++) dat[g] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;

    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (txd !== 3'b111 || rdy !== 3'b111 || busy !== 3'b000) bad++;
    end
    check("idle_after_reset", bad, 0);
    @(posedge clk);
    #1;

    send(0, 8'h41);
    measure_busy(0, 100, "busy_A");
    wait_idle();

    c0 = acc_cnt[0];
    vld[0] = 1'b1;
    dat[0] = 8'h55;
    n = 0;
    while (acc_cnt[0] == c0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    k1 = acc_edge[0];
    repeat (5) @(posedge clk);
    #1;
    dat[0] = 8'h0F;
    repeat (55) @(posedge clk);
    #1;
    dat[0] = 8'hAA;
    n = 0;
    while (acc_cnt[0] < c0 + 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    vld[0] = 1'b0;
    check("b2b_accept_spacing", acc_edge[0] - k1, 100);
    measure_busy(0, 100, "b2b_second_busy");
    wait_idle();

    fork
      begin
        send(1, 8'h31);
        fork
          begin
            repeat (96) @(negedge clk);
            check("even_parity_0x31", int'(txd[1]), 1);
          end
          measure_busy(1, 120, "busy_8e2");
        join
      end
      begin
        send(2, 8'h31);
        fork
          begin
            repeat (86) @(negedge clk);
            check("odd_parity_0x31", int'(txd[2]), 0);
          end
          measure_busy(2, 100, "busy_7o1");
        join
      end
    join
    wait_idle();

    send(0, 8'hFF);
    repeat (45) @(posedge clk);
    #1;
    reset = 1'b1;
    vld[0] = 1'b1;
    dat[0] = 8'hA5;
    @(posedge clk);
    #1;
    check("reset_abort_txd", int'(txd[0]), 1);
    check("reset_abort_ready", int'(rdy[0]), 1);
    reset = 1'b0;
    vld[0] = 1'b0;
    @(posedge clk);
    #1;
    send(0, 8'h00);
    measure_busy(0, 100, "busy_after_reset");
    wait_idle();

    fork
      rand_burst(0);
      rand_burst(1);
      rand_burst(2);
    join
    wait_idle();
    check("frames_left", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
